// File: rtl/bch_correct_stream.sv
// bch_correct_stream
//   Buffers raw BCH codewords in NBUF sector buffers and, when the decoder
//   streams out its error-location words, emits each stored word XOR-ed with
//   the matching error word. The outputs also report a running count of
//   flipped bits and whether that count disagrees with the decoder's count.
//
// Ports
//   clk_in, rst_n_in            clock, synchronous active-low reset
//   start_in, data_in           sector load: start pulse with word 0, then
//                               one word per cycle
//   in_ready                    a load may start this cycle
//   err_start_in, err_in        error stream: start pulse with word 0
//   err_cnt_in                  decoder error count, taken with err_start_in
//   data_out, valid_out         corrected word, registered
//   first_out, last_out         word 0 / last word markers
//   flip_cnt_out                bits flipped so far in the current/last sector
//   mismatch_out                sector flip total != decoder error count
//   overflow_out                pulse when a start or err_start is dropped
//
// Engine  | meaning
// --------+----------------------------------------------------------------
// loading | words are being written into buffer wr_ptr, index wr_cnt
// reading | error words are applied to buffer rd_ptr, index rd_cnt
module bch_correct_stream #(
  parameter int DATA_BITS = 4348,
  parameter int BITS      = 8,
  parameter int NBUF      = 2,
  localparam int FW       = $clog2(DATA_BITS + 1)
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            start_in,
  input  logic [BITS-1:0] data_in,
  output logic            in_ready,
  input  logic            err_start_in,
  input  logic [BITS-1:0] err_in,
  input  logic [7:0]      err_cnt_in,
  output logic [BITS-1:0] data_out,
  output logic            valid_out,
  output logic            first_out,
  output logic            last_out,
  output logic [FW-1:0]   flip_cnt_out,
  output logic            mismatch_out,
  output logic            overflow_out
);

  localparam int WORDS = (DATA_BITS + BITS - 1) / BITS;
  localparam int PAD   = WORDS * BITS - DATA_BITS;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW    = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int CW    = $clog2(NBUF + 1);
  localparam int AW    = (NBUF * WORDS > 1) ? $clog2(NBUF * WORDS) : 1;

  // Pad bits sit in the LSBs of the last word.
  localparam logic [BITS-1:0] PAD_MASK = BITS'((64'd1 << PAD) - 64'd1);
  localparam logic [WCW-1:0]  LAST_W   = WCW'(WORDS - 1);
  localparam logic [PW-1:0]   LAST_P   = PW'(NBUF - 1);
  localparam logic [CW-1:0]   NBUF_C   = CW'(NBUF);

  logic [BITS-1:0] mem_q [NBUF*WORDS];

  logic            loading_q, loading_d;
  logic [WCW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            reading_q, reading_d;
  logic [WCW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   full_q, full_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [BITS-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic [FW-1:0]   flip_q, flip_d;
  logic            mism_q, mism_d;
  logic            ovf_q, ovf_d;

  logic            ld_go, rd_go, wr_en, rd_en, wr_done, rd_done;
  logic [WCW-1:0]  wr_idx, rd_idx;
  logic [AW-1:0]   wr_addr, rd_addr;
  logic [BITS-1:0] err_m, buf_word;
  logic [FW-1:0]   pop;

  assign in_ready = !loading_q && (full_q < NBUF_C);

  // Datapath decode: a start word is consumed in the same cycle it arrives.
  always_comb begin
    ld_go    = start_in && in_ready;
    rd_go    = err_start_in && !reading_q && (full_q != '0);
    wr_en    = ld_go || loading_q;
    rd_en    = rd_go || reading_q;
    wr_idx   = ld_go ? '0 : wr_cnt_q;
    rd_idx   = rd_go ? '0 : rd_cnt_q;
    wr_done  = wr_en && (wr_idx == LAST_W);
    rd_done  = rd_en && (rd_idx == LAST_W);
    wr_addr  = AW'(wr_ptr_q) * AW'(WORDS) + AW'(wr_idx);
    rd_addr  = AW'(rd_ptr_q) * AW'(WORDS) + AW'(rd_idx);
    buf_word = mem_q[rd_addr];
    err_m    = rd_done ? (err_in & ~PAD_MASK) : err_in;
    pop      = '0;
    for (int i = 0; i < BITS; i++) begin
      pop = pop + FW'(err_m[i]);
    end
  end

  // Load / read engines and buffer occupancy.
  always_comb begin
    loading_d = loading_q;
    wr_cnt_d  = wr_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    reading_d = reading_q;
    rd_cnt_d  = rd_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    if (wr_en) begin
      loading_d = !wr_done;
      wr_cnt_d  = wr_done ? '0 : wr_idx + WCW'(1);
      if (wr_done) wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_en) begin
      reading_d = !rd_done;
      rd_cnt_d  = rd_done ? '0 : rd_idx + WCW'(1);
      if (rd_done) rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({wr_done, rd_done})
      2'b10:   full_d = full_q + CW'(1);
      2'b01:   full_d = full_q - CW'(1);
      default: full_d = full_q;
    endcase
  end

  // Registered outputs; flip count and mismatch hold between sectors.
  always_comb begin
    data_d    = '0;
    valid_d   = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    flip_d    = flip_q;
    mism_d    = mism_q;
    err_cnt_d = rd_go ? err_cnt_in : err_cnt_q;
    ovf_d     = (start_in && !in_ready) || (err_start_in && !rd_go);
    if (rd_en) begin
      valid_d = 1'b1;
      first_d = (rd_idx == '0);
      last_d  = rd_done;
      data_d  = (buf_word ^ err_m) & (rd_done ? ~PAD_MASK : {BITS{1'b1}});
      flip_d  = (first_d ? '0 : flip_q) + pop;
      if (first_d) mism_d = 1'b0;
      if (rd_done) mism_d = (int'(flip_d) != int'(err_cnt_d));
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      loading_q <= 1'b0;
      wr_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      reading_q <= 1'b0;
      rd_cnt_q  <= '0;
      rd_ptr_q  <= '0;
      full_q    <= '0;
      err_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      flip_q    <= '0;
      mism_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      loading_q <= loading_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      reading_q <= reading_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      full_q    <= full_d;
      err_cnt_q <= err_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      last_q    <= last_d;
      flip_q    <= flip_d;
      mism_q    <= mism_d;
      ovf_q     <= ovf_d;
    end
  end

  // Buffer storage is not reset; sectors in flight are discarded by the
  // pointer/occupancy reset instead.
  always_ff @(posedge clk_in) begin
    if (rst_n_in && wr_en) mem_q[wr_addr] <= data_in;
  end

  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign first_out    = first_q;
  assign last_out     = last_q;
  assign flip_cnt_out = flip_q;
  assign mismatch_out = mism_q;
  assign overflow_out = ovf_q;

endmodule
